// File: rtl/neq_reg_pkg.sv
// rtl/neq_reg_pkg.sv - shared constants for the neq_reg adder/flag block
package neq_reg_pkg;

    // Default data-path width in bits (two's-complement signed)
    localparam int NEQ_REG_WIDTH_DEF = 14;

    // Encoding of the sub operation-select input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : neq_reg_pkg

// File: rtl/neq_load_reg.sv
// rtl/neq_load_reg.sv - WIDTH-bit register with load enable and async active-low reset
module neq_load_reg
    import neq_reg_pkg::*;
#(
    parameter int WIDTH = NEQ_REG_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value: take d_i when loading, otherwise hold
    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = d_i;
        end
    end

    // State register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : neq_load_reg

// File: rtl/neq_reg.sv
// rtl/neq_reg.sv - signed add/sub with overflow flag, result register and sticky not-equal flag (option: NEQ_REG_SAT_EN saturates sum)
module neq_reg
    import neq_reg_pkg::*;
#(
    parameter int WIDTH = NEQ_REG_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ld,
    input  logic             en_neq,
    input  logic             init_nq,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic [WIDTH-1:0] q,
    output logic             neq_out
);

    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] carry_in;
    logic             neq_q;
    logic             neq_d;

    // Subtraction is a + ~b + 1: the inverted operand is what really enters the adder
    assign b_op     = (sub == OP_SUB) ? ~b : b;
    assign carry_in = {{(WIDTH-1){1'b0}}, sub};
    assign raw_sum  = a + b_op + carry_in;

    // Overflow: adder operands share a sign that the result does not
    assign ovf = (a[WIDTH-1] == b_op[WIDTH-1]) && (raw_sum[WIDTH-1] != a[WIDTH-1]);

`ifdef NEQ_REG_SAT_EN
    // On overflow clamp toward the operands' common sign
    always_comb begin
        sum = raw_sum;
        if (ovf) begin
            if (a[WIDTH-1]) begin
                sum = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                sum = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end
`else
    // Plain modulo-2^WIDTH wrap
    assign sum = raw_sum;
`endif

    // Result register
    neq_load_reg #(
        .WIDTH (WIDTH)
    ) u_q_reg (
        .clk   (clk),
        .rst_n (rst),
        .ld_i  (ld),
        .d_i   (sum),
        .q_o   (q)
    );

    // Sticky flag next state: clear wins over set, otherwise hold
    always_comb begin
        neq_d = neq_q;
        if (init_nq) begin
            neq_d = 1'b0;
        end else if (en_neq) begin
            neq_d = 1'b1;
        end
    end

    // Sticky flag register, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neq_q <= 1'b0;
        end else begin
            neq_q <= neq_d;
        end
    end

    assign neq_out = neq_q;

endmodule : neq_reg

// File: tb/tb_neq_reg.sv
// tb/tb_neq_reg.sv - self-checking randomized bench for neq_reg against an arithmetic reference model
module tb_neq_reg;

    localparam int     W     = 14;
    localparam longint MAXV  = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV  = -(longint'(1) <<< (W - 1));
    localparam longint RANGE = longint'(1) <<< W;

    logic                clk;
    logic                rst;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                sub;
    logic                ld;
    logic                en_neq;
    logic                init_nq;
    logic        [W-1:0] sum;
    logic                ovf;
    logic        [W-1:0] q;
    logic                neq_out;

    int     n_cmp = 0;
    int     n_err = 0;
    longint q_m   = 0;
    bit     f_m   = 1'b0;

    neq_reg #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .sub     (sub),
        .ld      (ld),
        .en_neq  (en_neq),
        .init_nq (init_nq),
        .sum     (sum),
        .ovf     (ovf),
        .q       (q),
        .neq_out (neq_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Exact integer arithmetic, then wrap or clamp into the signed WIDTH range
    function automatic void model(input longint av, input longint bv, input bit s,
                                  output longint es, output bit eo);
        longint r;
        longint t;
        r  = s ? (av - bv) : (av + bv);
        eo = (r > MAXV) || (r < MINV);
`ifdef NEQ_REG_SAT_EN
        es = (r > MAXV) ? MAXV : ((r < MINV) ? MINV : r);
`else
        t  = (((r - MINV) % RANGE) + RANGE) % RANGE;
        es = t + MINV;
`endif
    endfunction

    function automatic longint sx(input logic [W-1:0] v);
        logic signed [W-1:0] t;
        t = v;
        return longint'(t);
    endfunction

    // Called right after inputs are driven at a falling edge; ends at the next falling edge
    task automatic step(input string tag);
        longint es;
        bit     eo;
        model(longint'(a), longint'(b), sub, es, eo);
        #1;
        chk({tag, ".sum"}, sx(sum), es);
        chk({tag, ".ovf"}, longint'(ovf), longint'(eo));
        @(posedge clk);
        if (ld) q_m = es;
        if (init_nq) f_m = 1'b0;
        else if (en_neq) f_m = 1'b1;
        #1;
        chk({tag, ".q"}, sx(q), q_m);
        chk({tag, ".neq"}, longint'(neq_out), longint'(f_m));
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return MAXV[W-1:0];
            1: return MINV[W-1:0];
            2: return '0;
            3: return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b0; a = '0; b = '0; sub = 1'b0; ld = 1'b0; en_neq = 1'b0; init_nq = 1'b0;
        #2;
        chk("reset.q", sx(q), 0);
        chk("reset.neq", longint'(neq_out), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Basic add and subtract, then load
        a = 14'sd192; b = -14'sd64; sub = 1'b0;
        #1;
        chk("add.sum", sx(sum), 128);
        chk("add.ovf", longint'(ovf), 0);
        sub = 1'b1;
        #1;
        chk("sub.sum", sx(sum), 256);
        ld = 1'b1;
        @(negedge clk);
        step("sub_ld");
        ld = 1'b0;
        chk("sub_ld.q_const", sx(q), 256);

        // Positive overflow
        a = 14'sd8191; b = 14'sd1; sub = 1'b0;
        #1;
`ifdef NEQ_REG_SAT_EN
        chk("povf.sum_const", sx(sum), 8191);
`else
        chk("povf.sum_const", sx(sum), -8192);
`endif
        chk("povf.ovf_const", longint'(ovf), 1);
        step("povf");

        // Negative subtract overflow
        a = -14'sd8192; b = 14'sd1; sub = 1'b1;
        #1;
`ifdef NEQ_REG_SAT_EN
        chk("novf.sum_const", sx(sum), -8192);
`else
        chk("novf.sum_const", sx(sum), 8191);
`endif
        chk("novf.ovf_const", longint'(ovf), 1);
        step("novf");

        // Hold with changing operands
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
            step("hold");
            chk("hold.q_const", sx(q), 256);
        end

        // Sticky flag: pulse, hold five cycles, then set and clear together
        en_neq = 1'b1;
        step("flag_set");
        en_neq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("flag_hold");
            chk("flag_hold.const", longint'(neq_out), 1);
        end
        en_neq = 1'b1; init_nq = 1'b1;
        step("flag_both");
        chk("flag_both.const", longint'(neq_out), 0);
        en_neq = 1'b0; init_nq = 1'b0;

        // Randomized traffic with boundary-biased operands
        for (int i = 0; i < 400; i++) begin
            a = pick(); b = pick(); sub = 1'($urandom);
            ld = ($urandom_range(0, 2) != 0);
            en_neq = ($urandom_range(0, 5) == 0);
            init_nq = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        // Asynchronous reset mid-operation with load pending
        en_neq = 1'b1; init_nq = 1'b0; ld = 1'b1; a = 14'sd100; b = 14'sd5; sub = 1'b0;
        step("pre_rst");
        chk("pre_rst.neq_const", longint'(neq_out), 1);
        a = 14'sd77; b = 14'sd3;
        #2;
        rst = 1'b0;
        #1;
        chk("arst.q", sx(q), 0);
        chk("arst.neq", longint'(neq_out), 0);
        chk("arst.sum", sx(sum), 80);
        q_m = 0; f_m = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_edge.q", sx(q), 0);
        chk("arst_edge.neq", longint'(neq_out), 0);
        @(negedge clk);
        rst = 1'b1;
        en_neq = 1'b0;
        step("post_rst");
        chk("post_rst.q_const", sx(q), 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_neq_reg

// File: doc/neq_reg.md
NEQ_REG -- requirements
Module: neq_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 14, giving the data-path width in bits (two's-complement signed); legal range 2..32.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port a, input, WIDTH, signed first operand.
REQ-006 SHALL have port b, input, WIDTH, signed second operand.
REQ-007 SHALL have port sub, input, 1, operation select (0 = a+b, 1 = a-b).
REQ-008 SHALL have port ld, input, 1, load enable for the result register.
REQ-009 SHALL have port en_neq, input, 1, sets the sticky not-equal flag.
REQ-010 SHALL have port init_nq, input, 1, clears the sticky not-equal flag.
REQ-011 SHALL have port sum, output, WIDTH, combinational a±b.
REQ-012 SHALL have port ovf, output, 1, combinational signed overflow of the current operation.
REQ-013 SHALL have port q, output, WIDTH, registered result.
REQ-014 SHALL have port neq_out, output, 1, sticky not-equal flag.

Function
REQ-015 SHALL compute sum = a + b when sub=0, and sum = a + ~b + 1 when sub=1, truncated to WIDTH bits.
REQ-016 SHALL assert ovf when both operands entering the adder have the same sign and the result sign differs.
REQ-017 SHALL load q <= sum on the rising clk edge when ld=1, and hold q when ld=0; latency from operands to q is 1 cycle.
REQ-018 SHALL clear neq_out to 0 on the rising edge when init_nq=1.
REQ-019 SHALL set neq_out to 1 on the rising edge when en_neq=1 and init_nq=0.
REQ-020 SHALL hold neq_out when both en_neq and init_nq are 0; once set, it stays 1 until it is cleared or reset.
REQ-021 SHALL give init_nq priority over en_neq when both are 1 (result: 0).
REQ-022 SHALL wrap modulo 2^WIDTH when the configuration macro is absent; for example, with WIDTH=14, 8191+1 gives -8192 and ovf=1.
REQ-023 SHALL have no combinational path from ld, en_neq or init_nq to any output.

Reset
REQ-024 SHALL force q=0 and neq_out=0 immediately when rst=0, independent of clk.
REQ-025 SHALL give reset priority over ld, en_neq and init_nq; registers resume updating on the first rising edge after rst returns to 1.
REQ-026 SHALL keep sum and ovf purely combinational, so they are unaffected by reset.

Configuration
REQ-027 SHALL recognise the macro NEQ_REG_SAT_EN.
REQ-028 With NEQ_REG_SAT_EN defined, the module SHALL saturate sum on overflow: positive overflow gives 2^(WIDTH-1)-1, negative overflow gives -2^(WIDTH-1), and ovf still flags the event.
REQ-029 Without NEQ_REG_SAT_EN, the module SHALL produce the wrapped result per REQ-022 and SHALL contain no saturation logic.

Structure
REQ-030 SHALL take the default WIDTH constant (14) and the sub encoding constants (OP_ADD=0, OP_SUB=1) from the shared package neq_reg_pkg.
REQ-031 SHALL implement the loadable register (async active-low reset, load enable, WIDTH parameter) as one sub-module, neq_load_reg, instantiated for q.
REQ-032 SHALL implement the adder/subtractor and the flag logic inline.

Verification
REQ-033 Reset: rst=0 mid-operation with ld=1 -> q=0 and neq_out=0 immediately, before the next clock edge.
REQ-034 Add/subtract: a=192, b=-64, sub=0 -> sum=128, ovf=0; sub=1 -> sum=256; ld=1 for one cycle -> q=256 after that edge.
REQ-035 Overflow, WIDTH=14: a=8191, b=1, sub=0 -> without macro sum=-8192, ovf=1; with NEQ_REG_SAT_EN sum=8191, ovf=1.
REQ-036 Hold: ld=0 with changing operands -> q unchanged across 3 cycles.
REQ-037 Flag: en_neq pulsed for 1 cycle -> neq_out=1 and stays 1 for 5 cycles; en_neq=1 and init_nq=1 together -> neq_out=0.
REQ-038 Negative subtract: a=-8192, b=1, sub=1 -> without macro sum=8191, ovf=1; with NEQ_REG_SAT_EN sum=-8192.
